regfile_writeback: RTL and testbench

Dual-issue writeback queue between the execution units and the 2-write/4-read register file. Accepts up to two results per cycle (program-ordered, slot 1 older), buffers them in order, and drains up to two per cycle onto the register file write ports. Drops x0 writes, resolves same-destination conflicts, and optionally provides forwarding lookups for the four decode source operands.

---
 rtl/rf_wb_pkg.sv | 21 ++
 rtl/regfile_writeback_if.sv | 62 ++++++
 rtl/rf_wb_bypass.sv | 47 ++++
 rtl/regfile_writeback.sv | 111 +++++++++++
 tb/tb_regfile_writeback.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the dual-issue register-file writeback queue.
// Used by every file of the block; the optional bypass is enabled with RF_WB_BYPASS_EN.
package rf_wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    typedef struct packed {
        reg_idx_t rd;
        xlen_t    data;
    } rf_wb_entry_t;

    // Two entries drained together target the same register: only the younger may write.
    function automatic logic same_rd_conflict(rf_wb_entry_t older, rf_wb_entry_t younger);
        return older.rd == younger.rd;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer / register-file side signals of regfile_writeback.
// Lookup ports and bypass outputs exist only when RF_WB_BYPASS_EN is defined.
interface regfile_writeback_if
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in1_valid;
    logic             in2_valid;
    reg_idx_t         in1_rd;
    reg_idx_t         in2_rd;
    xlen_t            in1_data;
    xlen_t            in2_data;
    logic             in_ready;
    logic             wb_stall;
    logic             write1;
    logic             write2;
    reg_idx_t         rd1;
    reg_idx_t         rd2;
    xlen_t            write1_data;
    xlen_t            write2_data;
    logic [CNT_W-1:0] count;

`ifdef RF_WB_BYPASS_EN
    reg_idx_t         instr1_rs1;
    reg_idx_t         instr1_rs2;
    reg_idx_t         instr2_rs1;
    reg_idx_t         instr2_rs2;
    logic [3:0]       byp_hit;
    xlen_t            byp_data0;
    xlen_t            byp_data1;
    xlen_t            byp_data2;
    xlen_t            byp_data3;

    modport master (
        output in1_valid, in2_valid, in1_rd, in2_rd, in1_data, in2_data, wb_stall,
               instr1_rs1, instr1_rs2, instr2_rs1, instr2_rs2,
        input  in_ready, write1, write2, rd1, rd2, write1_data, write2_data, count,
               byp_hit, byp_data0, byp_data1, byp_data2, byp_data3
    );

    modport slave (
        input  in1_valid, in2_valid, in1_rd, in2_rd, in1_data, in2_data, wb_stall,
               instr1_rs1, instr1_rs2, instr2_rs1, instr2_rs2,
        output in_ready, write1, write2, rd1, rd2, write1_data, write2_data, count,
               byp_hit, byp_data0, byp_data1, byp_data2, byp_data3
    );
`else
    modport master (
        output in1_valid, in2_valid, in1_rd, in2_rd, in1_data, in2_data, wb_stall,
        input  in_ready, write1, write2, rd1, rd2, write1_data, write2_data, count
    );

    modport slave (
        input  in1_valid, in2_valid, in1_rd, in2_rd, in1_data, in2_data, wb_stall,
        output in_ready, write1, write2, rd1, rd2, write1_data, write2_data, count
    );
`endif

endinterface

// File: rtl/rf_wb_bypass.sv
// Youngest-match forwarding search over the queued entries and the live write ports.
// Only instantiated when RF_WB_BYPASS_EN is defined.
module rf_wb_bypass
    import rf_wb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  reg_idx_t           lookup_idx,
    input  rf_wb_entry_t       entries [DEPTH],
    input  logic [PTR_W-1:0]   head,
    input  logic [PTR_W:0]     count,
    input  logic               port1_valid,
    input  rf_wb_entry_t       port1,
    input  logic               port2_valid,
    input  rf_wb_entry_t       port2,
    output logic               hit,
    output xlen_t              data
);

    logic [PTR_W-1:0] pos;

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        pos  = '0;
        if (lookup_idx != '0) begin
            if (port1_valid && port1.rd == lookup_idx) begin
                hit  = 1'b1;
                data = port1.data;
            end
            if (port2_valid && port2.rd == lookup_idx) begin
                hit  = 1'b1;
                data = port2.data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                pos = head + PTR_W'(k);
                if (k < int'(count) && entries[pos].rd == lookup_idx) begin
                    hit  = 1'b1;
                    data = entries[pos].data;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// In-order dual-issue writeback queue feeding the two register-file write ports.
// Define RF_WB_BYPASS_EN to build the four forwarding lookups.
module regfile_writeback
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_writeback_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    rf_wb_entry_t mem [DEPTH];
    ptr_t         head_q, tail_q;
    cnt_t         count_q;
    logic         in_ready_q;
    logic         write1_q, write2_q;
    rf_wb_entry_t port1_q, port2_q;

    logic         push1, push2, pop1, pop2;
    cnt_t         count_next;
    ptr_t         tail_slot2;
    rf_wb_entry_t pop_e1, pop_e2;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        push1      = in_ready_q && bus.in1_valid && (bus.in1_rd != '0);
        push2      = in_ready_q && bus.in2_valid && (bus.in2_rd != '0);
        pop1       = !bus.wb_stall && (count_q != '0);
        pop2       = !bus.wb_stall && (count_q >= cnt_t'(2));
        count_next = count_q + cnt_t'(push1) + cnt_t'(push2) - cnt_t'(pop1) - cnt_t'(pop2);
        tail_slot2 = tail_q + ptr_t'(push1);
        pop_e1     = mem[head_q];
        pop_e2     = mem[head_q + ptr_t'(1)];
    end

    // NOTE: queue storage has no reset; occupancy is tracked by count, so stale contents are never read as valid.
    always_ff @(posedge clk) begin
        if (push1) mem[tail_q]     <= '{rd: bus.in1_rd, data: bus.in1_data};
        if (push2) mem[tail_slot2] <= '{rd: bus.in2_rd, data: bus.in2_data};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            write1_q   <= 1'b0;
            write2_q   <= 1'b0;
            port1_q    <= '0;
            port2_q    <= '0;
        end else begin
            head_q     <= head_q + ptr_t'(pop1) + ptr_t'(pop2);
            tail_q     <= tail_q + ptr_t'(push1) + ptr_t'(push2);
            count_q    <= count_next;
            in_ready_q <= (cnt_t'(DEPTH) - count_next) >= cnt_t'(2);
            write1_q   <= pop1 && !(pop2 && same_rd_conflict(pop_e1, pop_e2));
            write2_q   <= pop2;
            if (pop1) port1_q <= pop_e1;
            if (pop2) port2_q <= pop_e2;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.count       = count_q;
    assign bus.write1      = write1_q;
    assign bus.write2      = write2_q;
    assign bus.rd1         = port1_q.rd;
    assign bus.rd2         = port2_q.rd;
    assign bus.write1_data = port1_q.data;
    assign bus.write2_data = port2_q.data;

`ifdef RF_WB_BYPASS_EN
    reg_idx_t lookup   [4];
    xlen_t    byp_data [4];

    assign lookup[0] = bus.instr1_rs1;
    assign lookup[1] = bus.instr1_rs2;
    assign lookup[2] = bus.instr2_rs1;
    assign lookup[3] = bus.instr2_rs2;

    for (genvar g = 0; g < 4; g++) begin : g_bypass
        rf_wb_bypass #(.DEPTH(DEPTH)) u_bypass (
            .lookup_idx  (lookup[g]),
            .entries     (mem),
            .head        (head_q),
            .count       (count_q),
            .port1_valid (write1_q),
            .port1       (port1_q),
            .port2_valid (write2_q),
            .port2       (port2_q),
            .hit         (bus.byp_hit[g]),
            .data        (byp_data[g])
        );
    end

    assign bus.byp_data0 = byp_data[0];
    assign bus.byp_data1 = byp_data[1];
    assign bus.byp_data2 = byp_data[2];
    assign bus.byp_data3 = byp_data[3];
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: vector table, in-order scoreboard, and
// hand-written stall/wrap, reset and (with RF_WB_BYPASS_EN) forwarding sequences.
module tb_regfile_writeback;
    import rf_wb_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_if #(.DEPTH(DEPTH)) bus ();

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic     v1;
        reg_idx_t r1;
        xlen_t    d1;
        logic     v2;
        reg_idx_t r2;
        xlen_t    d2;
        int       cnt;
        logic     w1;
        logic     w2;
        reg_idx_t er1;
        xlen_t    ed1;
        reg_idx_t er2;
        xlen_t    ed2;
    } vec_t;

    int           n_checks = 0;
    int           n_errors = 0;
    rf_wb_entry_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; accepted entries go to the scoreboard.
    task automatic drive(input logic v1, input reg_idx_t r1, input xlen_t d1,
                         input logic v2, input reg_idx_t r2, input xlen_t d2);
        logic acc;
        bus.in1_valid = v1;
        bus.in1_rd    = r1;
        bus.in1_data  = d1;
        bus.in2_valid = v2;
        bus.in2_rd    = r2;
        bus.in2_data  = d2;
        acc = bus.in_ready;
        @(posedge clk);
        if (acc) begin
            if (v1 && r1 != '0) exp_q.push_back('{rd: r1, data: d1});
            if (v2 && r2 != '0) exp_q.push_back('{rd: r2, data: d2});
        end
        #1;
        bus.in1_valid = 1'b0;
        bus.in2_valid = 1'b0;
    endtask

    // Scoreboard: every register-file write must match the next queued result in order.
    rf_wb_entry_t sb_a, sb_b;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.write2) begin
                if (exp_q.size() < 2) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_pair_underflow: got write2 with %0d queued, expected >=2", exp_q.size());
                end else begin
                    sb_a = exp_q.pop_front();
                    sb_b = exp_q.pop_front();
                    check("sb_write1_conflict", bus.write1, sb_a.rd != sb_b.rd);
                    if (sb_a.rd != sb_b.rd) begin
                        check("sb_rd1", bus.rd1, sb_a.rd);
                        check("sb_data1", bus.write1_data, sb_a.data);
                    end
                    check("sb_rd2", bus.rd2, sb_b.rd);
                    check("sb_data2", bus.write2_data, sb_b.data);
                end
            end else if (bus.write1) begin
                if (exp_q.size() < 1) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_single_underflow: got write1 with 0 queued, expected >=1");
                end else begin
                    sb_a = exp_q.pop_front();
                    check("sb_rd1_single", bus.rd1, sb_a.rd);
                    check("sb_data1_single", bus.write1_data, sb_a.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        int   guard;
        int   pushed;

        vecs[0] = '{1'b1, 5'd5,  32'hA5A5A5A5, 1'b1, 5'd6, 32'h12345678, 2, 1'b1, 1'b1, 5'd5,  32'hA5A5A5A5, 5'd6, 32'h12345678};
        vecs[1] = '{1'b1, 5'd7,  32'h1,        1'b1, 5'd7, 32'h2,        2, 1'b0, 1'b1, 5'd0,  32'h0,        5'd7, 32'h2};
        vecs[2] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd3, 32'h33,       1, 1'b1, 1'b0, 5'd3,  32'h33,       5'd0, 32'h0};
        vecs[3] = '{1'b1, 5'd4,  32'h44,       1'b0, 5'd0, 32'h0,        1, 1'b1, 1'b0, 5'd4,  32'h44,       5'd0, 32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h99,       1, 1'b1, 1'b0, 5'd9,  32'h99,       5'd0, 32'h0};
        vecs[5] = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0, 32'h66,       0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd0, 32'h0};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd1, 32'h0,        2, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd1, 32'h0};

        bus.in1_valid = 1'b0;
        bus.in2_valid = 1'b0;
        bus.in1_rd    = '0;
        bus.in2_rd    = '0;
        bus.in1_data  = '0;
        bus.in2_data  = '0;
        bus.wb_stall  = 1'b0;
`ifdef RF_WB_BYPASS_EN
        bus.instr1_rs1 = '0;
        bus.instr1_rs2 = '0;
        bus.instr2_rs1 = '0;
        bus.instr2_rs2 = '0;
`endif

        #12;
        check("rst_count", bus.count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_write1", bus.write1, 0);
        check("rst_write2", bus.write2, 0);
        check("rst_rd1", bus.rd1, 0);
        check("rst_rd2", bus.rd2, 0);
        check("rst_data1", bus.write1_data, 0);
        check("rst_data2", bus.write2_data, 0);
`ifdef RF_WB_BYPASS_EN
        check("rst_byp_hit", bus.byp_hit, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle pushes from an empty queue, drained on the following edge.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v1, vecs[i].r1, vecs[i].d1, vecs[i].v2, vecs[i].r2, vecs[i].d2);
            check($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_write1", i), bus.write1, vecs[i].w1);
            check($sformatf("vec%0d_write2", i), bus.write2, vecs[i].w2);
            if (vecs[i].w1) begin
                check($sformatf("vec%0d_rd1", i), bus.rd1, vecs[i].er1);
                check($sformatf("vec%0d_data1", i), bus.write1_data, vecs[i].ed1);
            end
            if (vecs[i].w2) begin
                check($sformatf("vec%0d_rd2", i), bus.rd2, vecs[i].er2);
                check($sformatf("vec%0d_data2", i), bus.write2_data, vecs[i].ed2);
            end
            check($sformatf("vec%0d_drained", i), bus.count, 0);
        end

        // Fill under stall until in_ready drops, then drain across the pointer wrap.
        bus.wb_stall = 1'b1;
        guard  = 0;
        pushed = 0;
        while (bus.in_ready && guard < 10) begin
            drive(1'b1, reg_idx_t'(pushed + 1), 32'hC000_0000 + pushed,
                  1'b1, reg_idx_t'(pushed + 2), 32'hC000_0001 + pushed);
            check("stall_no_write", bus.write1 | bus.write2, 0);
            pushed += 2;
            guard++;
        end
        if (guard >= 10) begin
            n_checks++;
            n_errors++;
            $display("FAIL fill_timeout: got in_ready still high after %0d pushes, expected low", guard);
        end
        check("full_count", bus.count, DEPTH);
        check("full_in_ready", bus.in_ready, 0);
        drive(1'b1, 5'd20, 32'hBAD0_0000, 1'b1, 5'd21, 32'hBAD0_0001);
        check("full_ignored", bus.count, DEPTH);

        bus.wb_stall = 1'b0;
        for (int j = 0; j < DEPTH / 2; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("drain%0d_count", j), bus.count, DEPTH - 2 * (j + 1));
            check($sformatf("drain%0d_writes", j), {bus.write1, bus.write2}, 2'b11);
        end
        @(posedge clk);
        #1;
        check("drain_idle", {bus.write1, bus.write2}, 2'b00);

`ifdef RF_WB_BYPASS_EN
        bus.wb_stall = 1'b1;
        drive(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22);
        bus.instr1_rs1 = 5'd0;
        bus.instr2_rs1 = 5'd9;
        bus.instr2_rs2 = 5'd13;
        #1;
        check("byp_q_hit2", bus.byp_hit[2], 1);
        check("byp_q_data2", bus.byp_data2, 32'h22);
        check("byp_idx0_nohit", bus.byp_hit[0], 0);
        check("byp_miss", bus.byp_hit[3], 0);
        bus.wb_stall = 1'b0;
        @(posedge clk);
        #1;
        check("byp_port_hit2", bus.byp_hit[2], 1);
        check("byp_port_data2", bus.byp_data2, 32'h22);
        @(posedge clk);
        #1;
        check("byp_gone", bus.byp_hit[2], 0);
        bus.instr2_rs1 = 5'd0;
        bus.instr2_rs2 = 5'd0;
`endif

        check("sb_all_written", exp_q.size(), 0);

        // Reset in the middle of a drain.
        bus.wb_stall = 1'b1;
        drive(1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h1212);
        drive(1'b1, 5'd13, 32'h1313, 1'b1, 5'd14, 32'h1414);
        drive(1'b1, 5'd15, 32'h1515, 1'b1, 5'd16, 32'h1616);
        bus.wb_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        check("middrain_write2", bus.write2, 1);
        rst_n = 1'b0;
        #1;
        check("arst_write1", bus.write1, 0);
        check("arst_write2", bus.write2, 0);
        check("arst_count", bus.count, 0);
        check("arst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_no_write", j), bus.write1 | bus.write2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
